// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses 7-byte remote-player frames (HEADER, x1, y1, x2, y2,
// flags, chk) popped from a UART RX FIFO, publishes the fields of every frame
// whose XOR checksum and reserved flag bits are good, and counts rejects.
module uart_frame_rx #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] current_x_1,
  output logic [7:0] current_y_1,
  output logic [7:0] current_x_2,
  output logic [7:0] current_y_2,
  output logic       player1_collision,
  output logic       player2_collision,
  output logic [1:0] selected_player,
  output logic       frame_valid,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  // Counter value reached on the last idle cycle that still counts as "in time".
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [2:0]  idx;
  logic [7:0]  csum;
  logic [7:0]  pay [0:4];
  logic [31:0] idle_cnt;
  logic        capture;
  logic        timeout;
  logic        chk_ok;
  logic        load_out;
  logic        err_inc;

  // A byte is taken only when the FIFO has one, no pop is pending and the
  // parser is not busy publishing a frame.
  assign capture = !rx_empty && !rd_uart && (state != COMMIT);
  assign timeout = ((state == PAYLOAD) || (state == CHECK)) && !capture &&
                   (idle_cnt >= TMO_LAST);
  assign chk_ok  = (r_data == csum) && (pay[4][7:4] == 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: header hunt, payload collection, checksum, publish.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (capture && (r_data == HEADER)) begin
          state_next = PAYLOAD;
        end else begin
          state_next = IDLE;
        end
      end
      PAYLOAD: begin
        if (capture && (idx == 3'd4)) begin
          state_next = CHECK;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          state_next = PAYLOAD;
        end
      end
      CHECK: begin
        if (capture) begin
          state_next = chk_ok ? COMMIT : IDLE;
        end else if (timeout) begin
          state_next = IDLE;
        end else begin
          state_next = CHECK;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: publish in COMMIT, one error per rejected frame.
  always_comb begin
    load_out = (state == COMMIT);
    if ((state == CHECK) && capture && !chk_ok) begin
      err_inc = 1'b1;
    end else if (timeout) begin
      err_inc = 1'b1;
    end else begin
      err_inc = 1'b0;
    end
  end

  // Byte capture path: pop strobe, payload store, running XOR, idle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_uart  <= 1'b0;
      idx      <= 3'd0;
      csum     <= 8'd0;
      idle_cnt <= 32'd0;
      for (int i = 0; i < 5; i++) begin
        pay[i] <= 8'd0;
      end
    end else begin
      rd_uart <= capture;
      if (capture || (state == IDLE) || (state == COMMIT)) begin
        idle_cnt <= 32'd0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if (capture && (state == IDLE) && (r_data == HEADER)) begin
        csum <= HEADER;
        idx  <= 3'd0;
      end else if (capture && (state == PAYLOAD)) begin
        pay[idx] <= r_data;
        csum     <= csum ^ r_data;
        idx      <= idx + 3'd1;
      end else begin
        csum <= csum;
        idx  <= idx;
      end
    end
  end

  // Published fields, frame strobe and saturating reject counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      current_x_1       <= 8'd0;
      current_y_1       <= 8'd0;
      current_x_2       <= 8'd0;
      current_y_2       <= 8'd0;
      player1_collision <= 1'b0;
      player2_collision <= 1'b0;
      selected_player   <= 2'd0;
      frame_valid       <= 1'b0;
      err_cnt           <= 8'd0;
    end else begin
      frame_valid <= load_out;
      if (load_out) begin
        current_x_1       <= pay[0];
        current_y_1       <= pay[1];
        current_x_2       <= pay[2];
        current_y_2       <= pay[3];
        player1_collision <= pay[4][0];
        player2_collision <= pay[4][1];
        selected_player   <= pay[4][3:2];
      end
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: feeds byte streams through a FIFO model and compares the
// parser's outputs to a frame-level reference model.
module tb_uart_frame_rx;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic [7:0] current_x_1, current_y_1, current_x_2, current_y_2;
  logic       player1_collision, player2_collision;
  logic [1:0] selected_player;
  logic       frame_valid;
  logic [7:0] err_cnt;

  uart_frame_rx #(.HEADER(HDR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart),
    .current_x_1(current_x_1), .current_y_1(current_y_1),
    .current_x_2(current_x_2), .current_y_2(current_y_2),
    .player1_collision(player1_collision), .player2_collision(player2_collision),
    .selected_player(selected_player), .frame_valid(frame_valid),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] fifo [$];
  logic [7:0] mbuf [$];
  logic [7:0] m_x1 = 8'd0, m_y1 = 8'd0, m_x2 = 8'd0, m_y2 = 8'd0, m_flags = 8'd0;
  int         m_err = 0;
  int         exp_fv = 0, exp_pop = 0;
  int         seen_fv = 0, seen_pop = 0;
  logic       prev_rd = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
  endtask

  // Frame-level model: collect 7 bytes starting at a header, then judge them.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    if (mbuf.size() == 0) begin
      if (b == HDR) mbuf.push_back(b);
    end else begin
      mbuf.push_back(b);
      if (mbuf.size() == 7) begin
        x = 8'h00;
        for (int i = 0; i < 6; i++) x = x ^ mbuf[i];
        if ((mbuf[6] == x) && (mbuf[5][7:4] == 4'h0)) begin
          m_x1 = mbuf[1]; m_y1 = mbuf[2]; m_x2 = mbuf[3]; m_y2 = mbuf[4];
          m_flags = mbuf[5];
          exp_fv++;
        end else begin
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        mbuf.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    fifo.push_back(b);
    exp_pop++;
    refresh();
  endtask

  task automatic send_frame(input logic [7:0] x1, y1, x2, y2, fl, input logic [7:0] chk_flip);
    logic [7:0] c;
    c = HDR ^ x1 ^ y1 ^ x2 ^ y2 ^ fl ^ chk_flip;
    send(HDR); send(x1); send(y1); send(x2); send(y2); send(fl); send(c);
  endtask

  task automatic settle();
    int k;
    k = 0;
    while ((fifo.size() != 0) && (k < 10000)) begin
      @(negedge clk);
      k++;
    end
    if (fifo.size() != 0) check("drain", 32'd0, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x1"}, 32'(current_x_1), 32'(m_x1));
    check({tag, ".y1"}, 32'(current_y_1), 32'(m_y1));
    check({tag, ".x2"}, 32'(current_x_2), 32'(m_x2));
    check({tag, ".y2"}, 32'(current_y_2), 32'(m_y2));
    check({tag, ".p1"}, 32'(player1_collision), 32'(m_flags[0]));
    check({tag, ".p2"}, 32'(player2_collision), 32'(m_flags[1]));
    check({tag, ".sel"}, 32'(selected_player), 32'(m_flags[3:2]));
    check({tag, ".err"}, 32'(err_cnt), 32'(m_err));
    check({tag, ".fv_n"}, 32'(seen_fv), 32'(exp_fv));
    check({tag, ".pop_n"}, 32'(seen_pop), 32'(exp_pop));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mbuf.delete();
    m_x1 = 8'd0; m_y1 = 8'd0; m_x2 = 8'd0; m_y2 = 8'd0; m_flags = 8'd0;
    m_err = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // FIFO model: a pop strobe seen at an edge removes the head just after it.
  always @(posedge clk) begin
    logic do_pop;
    do_pop = rd_uart;
    #1;
    if (do_pop && (fifo.size() > 0)) void'(fifo.pop_front());
    refresh();
  end

  // Strobe monitor: count pops and frame pulses; a pulse must follow the chk pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_uart) seen_pop++;
      if (frame_valid) begin
        seen_fv++;
        check("fv_latency", 32'(prev_rd), 32'd1);
      end
    end
    prev_rd = rd_uart;
  end

  initial begin
    logic [7:0] g, y1;
    int kind;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.rd", 32'(rd_uart), 32'd0);
    check("reset.fv", 32'(frame_valid), 32'd0);
    check_all("reset");

    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h05, 8'h00);
    check("good.chk_byte", 32'(fifo[6]), 32'hE0);
    settle();
    check_all("good");
    check("good.x1_lit", 32'(current_x_1), 32'h10);
    check("good.sel_lit", 32'(selected_player), 32'd1);

    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h01);
    settle();
    check_all("badchk");
    check("badchk.err_lit", 32'(err_cnt), 32'd1);

    send(8'h00); send(8'hFF); send(8'h3C);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h00);
    settle();
    check_all("garbage");

    send(HDR); send(8'h10); send(8'h20);
    settle();
    repeat (TMO + 20) @(negedge clk);
    mbuf.delete();
    m_err = m_err + 1;
    check_all("timeout");
    send_frame(8'h55, 8'h66, 8'h77, 8'h88, 8'h06, 8'h00);
    settle();
    check_all("after_tmo");

    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'hF5, 8'h00);
    settle();
    check_all("badflags");

    send(HDR); send(8'h10); send(8'h20); send(8'h30);
    settle();
    do_reset();
    @(negedge clk);
    check_all("midreset");
    check("midreset.x1_lit", 32'(current_x_1), 32'd0);
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h05, 8'h00);
    settle();
    check_all("post_reset");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      y1 = (kind == 4) ? HDR : 8'($urandom);
      if (kind == 3) begin
        for (int j = 0; j < 3; j++) begin
          g = 8'($urandom);
          if (g == HDR) g = 8'h00;
          send(g);
        end
      end
      send_frame(8'($urandom), y1, 8'($urandom), 8'($urandom),
                 (kind == 2) ? {4'(1 + $urandom_range(0, 14)), 4'($urandom)}
                             : {4'h0, 4'($urandom)},
                 (kind == 1) ? 8'(1 + $urandom_range(0, 254)) : 8'h00);
      settle();
      check_all($sformatf("rand%0d", n));
    end

    for (int n = 0; n < 300; n++) begin
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h03, 8'h5A);
    end
    settle();
    check_all("saturate");
    check("saturate.lit", 32'(err_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter HEADER, default 8'hA5, start-of-frame byte value.
REQ-002 Parameter TIMEOUT_CYCLES, default 650000, max idle cycles between bytes inside a frame (10 ms at 65 MHz).
REQ-003 clk  input  1  system clock (clk65MHz domain); one clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_empty  input  1  UART RX FIFO empty flag; r_data valid when low.
REQ-006 r_data  input  8  UART RX FIFO head byte.
REQ-007 rd_uart  output  1  one-cycle FIFO pop strobe.
REQ-008 current_x_1, current_y_1, current_x_2, current_y_2  output  8 each  remote player tile coordinates.
REQ-009 player1_collision, player2_collision  output  1 each  remote collision flags.
REQ-010 selected_player  output  2  remote player selection.
REQ-011 frame_valid  output  1  one-cycle pulse when outputs updated from a good frame.
REQ-012 err_cnt  output  8  saturating count of rejected frames.

Function
REQ-013 Frame format SHALL be 7 bytes: HEADER, x1, y1, x2, y2, flags, chk; chk = XOR of the preceding 6 bytes.
REQ-014 flags SHALL decode as bit0 player1_collision, bit1 player2_collision, bits3:2 selected_player; bits7:4 SHALL be 0 or the frame is rejected.
REQ-015 Byte acceptance: when rx_empty=0 and rd_uart=0, r_data SHALL be captured that cycle and rd_uart asserted the next cycle; no capture while rd_uart=1 (max one byte per 2 cycles).
REQ-016 FSM states SHALL be IDLE, PAYLOAD, CHECK, COMMIT.
REQ-017 IDLE: captured byte == HEADER -> PAYLOAD, running XOR = HEADER, byte index = 0; any other byte SHALL be popped and discarded.
REQ-018 PAYLOAD: each captured byte stored at index 0..4 and XORed into running checksum; after index 4 -> CHECK.
REQ-019 A HEADER value received in PAYLOAD SHALL be treated as ordinary data (no resync).
REQ-020 CHECK: captured byte == running XOR and flags bits7:4 == 0 -> COMMIT; otherwise err_cnt increments, -> IDLE, outputs hold.
REQ-021 COMMIT: all data outputs SHALL update from stored bytes and frame_valid pulse high for exactly that cycle; -> IDLE next cycle; no byte captured in COMMIT.
REQ-022 Latency: outputs/frame_valid SHALL change 2 cycles after the cycle chk is captured (CHECK capture -> COMMIT -> registered outputs).
REQ-023 Timeout: idle counter resets on each capture; in PAYLOAD or CHECK, TIMEOUT_CYCLES cycles without capture SHALL -> IDLE and increment err_cnt.
REQ-024 err_cnt SHALL saturate at 255; checksum error and timeout in the same cycle SHALL count once.
REQ-025 Outputs SHALL hold last good values between frames and after any rejected frame.

Reset
REQ-026 On rst: state IDLE, rd_uart=0, frame_valid=0, err_cnt=0, all coordinates 0, collisions 0, selected_player=0, index, checksum and timeout counters 0.
REQ-027 rst asserted mid-frame SHALL abandon the partial frame without incrementing err_cnt; bytes already in the FIFO are parsed after reset from IDLE.

Verification
REQ-028 Good frame A5 10 20 30 40 05 E0 -> x1=10, y1=20, x2=30, y2=40, p1_coll=1, p2_coll=0, selected_player=01, one frame_valid pulse, err_cnt=0.
REQ-029 Same frame with chk=E1 -> outputs unchanged, no frame_valid, err_cnt=1.
REQ-030 Leading garbage 00 FF 3C then good frame -> garbage popped (3 extra rd_uart pulses), frame accepted once.
REQ-031 A5 10 20 then FIFO empty for TIMEOUT_CYCLES -> IDLE, err_cnt+1; following good frame accepted.
REQ-032 Flags byte F5 with matching chk -> rejected, err_cnt+1; 300 bad frames -> err_cnt=255.
REQ-033 rst during byte 4 of a frame, then good frame -> all outputs 0 after reset, err_cnt=0, then frame accepted.
